reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular reorder buffer between issue/decode and the architectural register file.
- Allocates a ROB tag per issued instruction and drives the register file's rename inputs (new_reg_id/new_ROB_id).
- Collects results from the ALU and LSB broadcast buses and answers operand-forwarding lookups (rs1_id/rs2_id).
- Retires in order, driving commit writes (write_reg_id/write_ROB_id/write_val); detects branch mispredicts, raising clear_flag and a redirect PC.

Parameters:
ROB_WIDTH_BIT, 4, tag width; depth = 2**ROB_WIDTH_BIT (16 entries)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  pause when low
issue_valid  in  1  decoder presents an instruction
issue_ready  out  1  ROB accepts this cycle
issue_type  in  2  0=reg-writing, 1=store, 2=branch
issue_rd  in  5  destination register (0 = none)
issue_pc  in  32  instruction PC
issue_pred_jump  in  1  predicted taken
issue_rob_id  out  ROB_WIDTH_BIT  tag given to the issuing instruction (= tail)
new_reg_id  out  5  rename target to the register file, 0 when none
new_ROB_id  out  ROB_WIDTH_BIT  rename tag
alu_valid  in  1  ALU broadcast
alu_rob_id  in  ROB_WIDTH_BIT  ALU result tag
alu_val  in  32  ALU result
alu_jump  in  1  actual branch taken
alu_target  in  32  actual branch target
lsb_valid  in  1  LSB broadcast (load data or store address ready)
lsb_rob_id  in  ROB_WIDTH_BIT  LSB result tag
lsb_val  in  32  load data
rs1_id  in  ROB_WIDTH_BIT  lookup tag 1
rs1_ready  out  1  tag 1 value available
rs1_val  out  32  tag 1 value
rs2_id, rs2_ready, rs2_val: same as the rs1 trio, for tag 2
write_reg_id  out  5  commit destination, 0 = no write
write_ROB_id  out  ROB_WIDTH_BIT  committing tag
write_val  out  32  committing value
store_commit  out  1  head store retires this cycle
store_rob_id  out  ROB_WIDTH_BIT  committing store tag
clear_flag  out  1  flush pulse
redirect_pc  out  32  fetch PC valid while clear_flag=1

Behaviour:
- Reset (rst_in low, async):
  - head, tail and count are 0; all busy/ready bits are 0.
  - clear_flag and redirect_pc are 0.
  - All commit outputs are 0, and new_reg_id is 0.
- Entry fields: busy, ready, type, rd, val, pc, pred_jump, act_jump, target.
- Full and issue handshake:
  - full = (count == 2**ROB_WIDTH_BIT).
  - issue_ready = rdy_in & !full & !clear_flag. Full is computed from the registered count; a same-cycle commit does not free a slot for issue.
  - accept = issue_valid & issue_ready.
  - new_reg_id = accept ? issue_rd : 0, combinational; new_ROB_id = tail.
  - On an accepting edge: the entry at tail becomes busy with ready=0, and tail and count increment. Tail wraps modulo depth.
- Writeback:
  - On alu_valid or lsb_valid, the matching busy entry gets ready=1 and val. From ALU it also gets act_jump and target. A broadcast to a non-busy entry is ignored.
  - If both buses hit the same tag, ALU wins.
  - Ready becomes visible to commit one cycle after the broadcast.
- Lookup (combinational):
  - rsX_ready = entry ready, or a same-cycle alu/lsb broadcast to rsX_id.
  - rsX_val takes the bypass value when bypassing, otherwise the stored val.
- Commit:
  - commit_fire = rdy_in & !clear_flag & head busy & head ready.
  - While commit_fire is high, these outputs are driven combinationally from the head:
    - write_reg_id = rd (type 0 only, else 0); write_ROB_id = head; write_val = val.
    - store_commit = 1 for type 1, with store_rob_id = head.
  - When commit_fire is low, all commit outputs are 0.
  - On the edge: head is cleared (busy=0), head increments with wrap, and count decrements.
  - Simultaneous issue and commit leaves count unchanged.
- Mispredict (commit of type 2 with act_jump != pred_jump):
  - On that edge, head, tail and count go to 0 and every busy bit is cleared.
  - clear_flag is registered to 1 for exactly one cycle.
  - redirect_pc = act_jump ? target : pc+4.
  - The branch still writes rd (JAL/JALR link) when rd != 0.
  - While clear_flag=1: no issue, no commit, and broadcasts are ignored.
- A correctly predicted branch commits normally with clear_flag=0.
- rdy_in low:
  - All state is held; issue_ready=0 and commit outputs are 0.
  - Lookups stay functional.
- An async reset mid-flush aborts everything; state returns to the reset values immediately.

Test Plan:
- Issue 3 type-0 instructions (rd=5,6,7) -> tags 0,1,2 returned; new_reg_id=5,6,7 on the accept cycles; count=3.
- ALU broadcasts tag1 val=0x11, then tag0 val=0x22 -> tag0 commits first (write_reg_id=5, write_val=0x22); tag1 commits the next cycle (write_reg_id=6, write_val=0x11).
- Fill 16 entries -> issue_ready=0. Hold issue_valid while the head commits -> no accept that cycle, accept on the next cycle. Tail wraps to 0, then 1.
- Lookup rs1_id=2 in the same cycle as an LSB broadcast of tag2 val=0xABCD -> rs1_ready=1, rs1_val=0xABCD.
- Branch at pc=0x100, pred_jump=0; ALU reports jump=1, target=0x200 -> at commit, clear_flag=1 for one cycle, redirect_pc=0x200, count=0; younger entries never commit.
- Store at the head made ready by LSB -> store_commit=1 with store_rob_id=head and write_reg_id=0. Pull rdy_in low mid-stream -> all outputs hold/zero as specified and state is frozen.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, collects ALU/LSB results,
// forwards operands to dispatch, retires in order and flushes on a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic [31:0]              issue_pc,
    input  logic                     issue_pred_jump,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    output logic [4:0]               new_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
    input  logic                     alu_valid,
    input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
    input  logic [31:0]              alu_val,
    input  logic                     alu_jump,
    input  logic [31:0]              alu_target,
    input  logic                     lsb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_val,
    input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
    output logic                     rs1_ready,
    output logic [31:0]              rs1_val,
    input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
    output logic                     rs2_ready,
    output logic [31:0]              rs2_val,
    output logic [4:0]               write_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    output logic [31:0]              write_val,
    output logic                     store_commit,
    output logic [ROB_WIDTH_BIT-1:0] store_rob_id,
    output logic                     clear_flag,
    output logic [31:0]              redirect_pc
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam int CW    = ROB_WIDTH_BIT + 1;

    localparam logic [CW-1:0]            CNT_ONE   = {{ROB_WIDTH_BIT{1'b0}}, 1'b1};
    localparam logic [CW-1:0]            CNT_FULL  = {1'b1, {ROB_WIDTH_BIT{1'b0}}};
    localparam logic [CW-1:0]            CNT_ZERO  = {CW{1'b0}};
    localparam logic [ROB_WIDTH_BIT-1:0] PTR_ONE   = {{(ROB_WIDTH_BIT-1){1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH_BIT-1:0] PTR_ZERO  = {ROB_WIDTH_BIT{1'b0}};

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    // Entry storage
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] act_q;
    logic [1:0]       type_q   [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      val_q    [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      target_q [DEPTH];

    // Pointers and flush state
    logic [ROB_WIDTH_BIT-1:0] head_q;
    logic [ROB_WIDTH_BIT-1:0] tail_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic                     clear_q;
    logic [31:0]              redirect_q;

    logic        full_s;
    logic        accept_s;
    logic        commit_fire_s;
    logic        mispredict_s;
    logic [1:0]  head_type_s;
    logic [31:0] redirect_target_s;
    logic        lsb_hit_s;

    assign full_s        = (count_q == CNT_FULL);
    assign issue_ready   = rdy_in & ~full_s & ~clear_q;
    assign accept_s      = issue_valid & issue_ready;
    assign issue_rob_id  = tail_q;
    assign new_ROB_id    = tail_q;
    assign new_reg_id    = accept_s ? issue_rd : 5'd0;

    assign head_type_s   = type_q[head_q];
    assign commit_fire_s = rdy_in & ~clear_q & busy_q[head_q] & ready_q[head_q];
    assign mispredict_s  = commit_fire_s & (head_type_s == TYPE_BRANCH)
                         & (act_q[head_q] != pred_q[head_q]);
    assign redirect_target_s = act_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);

    // An LSB result only lands when the ALU is not writing the same tag this cycle
    assign lsb_hit_s = lsb_valid & busy_q[lsb_rob_id] & ~(alu_valid & (alu_rob_id == lsb_rob_id));

    assign clear_flag  = clear_q;
    assign redirect_pc = redirect_q;

    // Occupancy next-state: issue and commit in the same cycle cancel out
    always_comb begin
        count_d = count_q;
        case ({accept_s, commit_fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Commit outputs, driven straight from the head entry while it retires
    always_comb begin
        write_reg_id = 5'd0;
        write_ROB_id = PTR_ZERO;
        write_val    = 32'd0;
        store_commit = 1'b0;
        store_rob_id = PTR_ZERO;
        if (commit_fire_s) begin
            write_ROB_id = head_q;
            write_val    = val_q[head_q];
            case (head_type_s)
                TYPE_REG:    write_reg_id = rd_q[head_q];
                TYPE_BRANCH: write_reg_id = rd_q[head_q];
                TYPE_STORE: begin
                    store_commit = 1'b1;
                    store_rob_id = head_q;
                end
                default:     write_reg_id = 5'd0;
            endcase
        end else begin
            write_reg_id = 5'd0;
        end
    end

    // Operand lookup for rs1 with same-cycle broadcast bypass (ALU has priority)
    always_comb begin
        rs1_ready = ready_q[rs1_id];
        rs1_val   = val_q[rs1_id];
        if (alu_valid && (alu_rob_id == rs1_id)) begin
            rs1_ready = 1'b1;
            rs1_val   = alu_val;
        end else if (lsb_valid && (lsb_rob_id == rs1_id)) begin
            rs1_ready = 1'b1;
            rs1_val   = lsb_val;
        end else begin
            rs1_ready = ready_q[rs1_id];
            rs1_val   = val_q[rs1_id];
        end
    end

    // Operand lookup for rs2 with same-cycle broadcast bypass (ALU has priority)
    always_comb begin
        rs2_ready = ready_q[rs2_id];
        rs2_val   = val_q[rs2_id];
        if (alu_valid && (alu_rob_id == rs2_id)) begin
            rs2_ready = 1'b1;
            rs2_val   = alu_val;
        end else if (lsb_valid && (lsb_rob_id == rs2_id)) begin
            rs2_ready = 1'b1;
            rs2_val   = lsb_val;
        end else begin
            rs2_ready = ready_q[rs2_id];
            rs2_val   = val_q[rs2_id];
        end
    end

    // Head/tail/count pointers and the one-cycle flush pulse with its redirect PC
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q     <= PTR_ZERO;
            tail_q     <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            clear_q    <= 1'b0;
            redirect_q <= 32'd0;
        end else begin
            clear_q    <= mispredict_s;
            redirect_q <= mispredict_s ? redirect_target_s : 32'd0;
            if (mispredict_s) begin
                head_q  <= PTR_ZERO;
                tail_q  <= PTR_ZERO;
                count_q <= CNT_ZERO;
            end else begin
                if (accept_s) begin
                    tail_q <= tail_q + PTR_ONE;
                end
                if (commit_fire_s) begin
                    head_q <= head_q + PTR_ONE;
                end
                count_q <= count_d;
            end
        end
    end

    // Entry state: writeback from the broadcast buses, allocation at tail, release at head
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= {DEPTH{1'b0}};
            ready_q <= {DEPTH{1'b0}};
            pred_q  <= {DEPTH{1'b0}};
            act_q   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= 2'd0;
                rd_q[i]     <= 5'd0;
                val_q[i]    <= 32'd0;
                pc_q[i]     <= 32'd0;
                target_q[i] <= 32'd0;
            end
        end else if (rdy_in && !clear_q) begin
            if (mispredict_s) begin
                busy_q <= {DEPTH{1'b0}};
            end else begin
                if (alu_valid && busy_q[alu_rob_id]) begin
                    ready_q[alu_rob_id]  <= 1'b1;
                    val_q[alu_rob_id]    <= alu_val;
                    act_q[alu_rob_id]    <= alu_jump;
                    target_q[alu_rob_id] <= alu_target;
                end
                if (lsb_hit_s) begin
                    ready_q[lsb_rob_id] <= 1'b1;
                    val_q[lsb_rob_id]   <= lsb_val;
                end
                if (accept_s) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= 1'b0;
                    type_q[tail_q]   <= issue_type;
                    rd_q[tail_q]     <= issue_rd;
                    pc_q[tail_q]     <= issue_pc;
                    pred_q[tail_q]   <= issue_pred_jump;
                    act_q[tail_q]    <= 1'b0;
                    val_q[tail_q]    <= 32'd0;
                    target_q[tail_q] <= 32'd0;
                end
                if (commit_fire_s) begin
                    busy_q[head_q] <= 1'b0;
                end
            end
        end
    end

endmodule
